// File: rtl/mem_wb_stage_pkg.sv
// Shared constants and types for the memory/write-back stage.
package mem_wb_stage_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_ZERO = 2'b11;

    typedef enum logic {
        StIdle,
        StLoadWait
    } state_e;

    // Unused funct3 encodings behave as LW, so they need word alignment too.
    function automatic logic is_misaligned(logic [2:0] funct3, logic [1:0] off);
        case (funct3)
            LOAD_LB, LOAD_LBU: return 1'b0;
            LOAD_LH, LOAD_LHU: return off[0];
            default:           return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory read handshake between the write-back stage (master) and memory (slave).
interface mem_wb_stage_if;
    import mem_wb_stage_pkg::*;

    logic            dmem_req;
    logic [XLEN-1:0] dmem_addr;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_addr,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_addr,
        output dmem_ack,
        output dmem_rdata
    );

endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load alignment: selects byte/halfword from the read word and extends it.
module mem_wb_stage_load_align
    import mem_wb_stage_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      off_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (off_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        data_o = rdata_i;
        case (funct3_i)
            LOAD_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
            LOAD_LBU: data_o = {24'b0, byte_sel};
            LOAD_LH:  data_o = {{16{half_sel[15]}}, half_sel};
            LOAD_LHU: data_o = {16'b0, half_sel};
            default:  data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/write-back pipeline stage: issues loads over a req/ack handshake and drives the
// register-file write port. Optional misaligned-load trapping under MISALIGN_TRAP_EN.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   pc_plus4,
    input  logic [REG_AW-1:0] rd_in,
    input  logic              reg_wr_in,
    input  logic [1:0]        wb_sel,
    input  logic [2:0]        funct3_in,
    output logic              stall_out,
    mem_wb_stage_if.master    dmem,
    output logic              wrEn,
    output logic [REG_AW-1:0] Rdst,
    output logic [XLEN-1:0]   RWrdata,
    output logic              misalign_trap
);

    state_e            state_q;
    logic              req_q;
    logic [XLEN-1:0]   addr_q;
    logic [REG_AW-1:0] ld_rd_q;
    logic [2:0]        ld_f3_q;
    logic [1:0]        ld_off_q;
    logic              wr_en_q;
    logic [REG_AW-1:0] rdst_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   wb_data;
    logic [XLEN-1:0]   load_data;

    always_comb begin
        wb_data = '0;
        case (wb_sel)
            WB_SEL_ALU: wb_data = alu_result;
            WB_SEL_PC4: wb_data = pc_plus4;
            default:    wb_data = '0;
        endcase
    end

    mem_wb_stage_load_align u_load_align (
        .rdata_i  (dmem.dmem_rdata),
        .off_i    (ld_off_q),
        .funct3_i (ld_f3_q),
        .data_o   (load_data)
    );

`ifdef MISALIGN_TRAP_EN
    logic trap_q;
    assign misalign_trap = trap_q;
`else
    assign misalign_trap = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            req_q    <= 1'b0;
            addr_q   <= '0;
            ld_rd_q  <= '0;
            ld_f3_q  <= '0;
            ld_off_q <= '0;
            wr_en_q  <= 1'b0;
            rdst_q   <= '0;
            wdata_q  <= '0;
`ifdef MISALIGN_TRAP_EN
            trap_q   <= 1'b0;
`endif
        end else begin
            // wrEn and the trap are one-cycle pulses unless re-asserted below.
            wr_en_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            trap_q  <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    if (valid_in) begin
                        if (wb_sel != WB_SEL_LOAD) begin
                            wr_en_q <= reg_wr_in & (rd_in != '0);
                            rdst_q  <= rd_in;
                            wdata_q <= wb_data;
                        end
`ifdef MISALIGN_TRAP_EN
                        else if (is_misaligned(funct3_in, alu_result[1:0])) begin
                            trap_q <= 1'b1;
                        end
`endif
                        else begin
                            req_q    <= 1'b1;
                            addr_q   <= {alu_result[XLEN-1:2], 2'b00};
                            ld_rd_q  <= rd_in;
                            ld_f3_q  <= funct3_in;
                            ld_off_q <= alu_result[1:0];
                            state_q  <= StLoadWait;
                        end
                    end
                end
                StLoadWait: begin
                    if (dmem.dmem_ack) begin
                        req_q   <= 1'b0;
                        wr_en_q <= ld_rd_q != '0;
                        rdst_q  <= ld_rd_q;
                        wdata_q <= load_data;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign stall_out      = state_q == StLoadWait;
    assign dmem.dmem_req  = req_q;
    assign dmem.dmem_addr = addr_q;
    assign wrEn           = wr_en_q;
    assign Rdst           = rdst_q;
    assign RWrdata        = wdata_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected write-backs queued at issue, checked on wrEn.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid_in;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic [4:0]  rd_in;
    logic        reg_wr_in;
    logic [1:0]  wb_sel;
    logic [2:0]  funct3_in;
    logic        stall_out;
    logic        wrEn;
    logic [4:0]  Rdst;
    logic [31:0] RWrdata;
    logic        misalign_trap;

    mem_wb_stage_if dmem_if ();

    mem_wb_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_in      (valid_in),
        .alu_result    (alu_result),
        .pc_plus4      (pc_plus4),
        .rd_in         (rd_in),
        .reg_wr_in     (reg_wr_in),
        .wb_sel        (wb_sel),
        .funct3_in     (funct3_in),
        .stall_out     (stall_out),
        .dmem          (dmem_if),
        .wrEn          (wrEn),
        .Rdst          (Rdst),
        .RWrdata       (RWrdata),
        .misalign_trap (misalign_trap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] addr,
                                               logic [31:0] rdata);
        logic [31:0] bs;
        logic [31:0] hs;
        bs = rdata >> {addr[1:0], 3'b000};
        hs = rdata >> {addr[1], 4'b0000};
        case (f3)
            3'b000:  return {{24{bs[7]}}, bs[7:0]};
            3'b100:  return {24'b0, bs[7:0]};
            3'b001:  return {{16{hs[15]}}, hs[15:0]};
            3'b101:  return {16'b0, hs[15:0]};
            default: return rdata;
        endcase
    endfunction

    // Every wrEn pulse must match the oldest expected write-back.
    always @(negedge clk) begin
        if (rst_n && wrEn === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("wren_spurious", 32'(wrEn), 32'd0);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check_eq("wb_rdst", 32'(Rdst), 32'(e.rd));
                check_eq("wb_data", RWrdata, e.data);
            end
        end
    end

    task automatic alu_op(input logic [4:0] rd, input logic reg_wr, input logic [1:0] sel,
                          input logic [31:0] alu, input logic [31:0] pc);
        logic [31:0] d;
        logic        we;
        @(posedge clk); #1;
        valid_in = 1'b1; wb_sel = sel; rd_in = rd; reg_wr_in = reg_wr;
        alu_result = alu; pc_plus4 = pc; funct3_in = 3'b000;
        d  = (sel == 2'b00) ? alu : (sel == 2'b10) ? pc : 32'd0;
        we = reg_wr && (rd != 5'd0);
        if (we) exp_q.push_back('{rd: rd, data: d});
        @(posedge clk); #1;
        valid_in = 1'b0;
        check_eq("alu_wren", 32'(wrEn), 32'(we));
        check_eq("alu_stall", 32'(stall_out), 32'd0);
    endtask

    task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                        input int delay, input logic [31:0] rdata);
        @(posedge clk); #1;
        valid_in = 1'b1; wb_sel = 2'b01; rd_in = rd; reg_wr_in = 1'b1;
        alu_result = addr; funct3_in = f3;
        if (rd != 5'd0) exp_q.push_back('{rd: rd, data: model_load(f3, addr, rdata)});
        @(posedge clk); #1;
        valid_in = 1'b0;
        alu_result = 32'hDEAD_BEEF;
        check_eq("ld_req", 32'(dmem_if.dmem_req), 32'd1);
        check_eq("ld_addr", dmem_if.dmem_addr, {addr[31:2], 2'b00});
        check_eq("ld_stall", 32'(stall_out), 32'd1);
        check_eq("ld_wren_early", 32'(wrEn), 32'd0);
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            check_eq("ld_req_hold", 32'(dmem_if.dmem_req), 32'd1);
            check_eq("ld_addr_hold", dmem_if.dmem_addr, {addr[31:2], 2'b00});
            check_eq("ld_stall_hold", 32'(stall_out), 32'd1);
        end
        dmem_if.dmem_ack = 1'b1;
        dmem_if.dmem_rdata = rdata;
        @(posedge clk); #1;
        dmem_if.dmem_ack = 1'b0;
        dmem_if.dmem_rdata = 32'h5A5A_5A5A;
        check_eq("ld_req_drop", 32'(dmem_if.dmem_req), 32'd0);
        check_eq("ld_stall_drop", 32'(stall_out), 32'd0);
        check_eq("ld_wren", 32'(wrEn), 32'(rd != 5'd0));
    endtask

    initial begin
        valid_in = 1'b0; alu_result = '0; pc_plus4 = '0; rd_in = '0;
        reg_wr_in = 1'b0; wb_sel = '0; funct3_in = '0;
        dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = '0;
        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_stall", 32'(stall_out), 32'd0);
        check_eq("rst_req", 32'(dmem_if.dmem_req), 32'd0);
        check_eq("rst_addr", dmem_if.dmem_addr, 32'd0);
        check_eq("rst_wren", 32'(wrEn), 32'd0);
        check_eq("rst_rdst", 32'(Rdst), 32'd0);
        check_eq("rst_wdata", RWrdata, 32'd0);
        check_eq("rst_trap", 32'(misalign_trap), 32'd0);
        #9 rst_n = 1'b1;

        alu_op(5'd5, 1'b1, 2'b00, 32'h0000_1234, 32'h0);
        alu_op(5'd7, 1'b1, 2'b10, 32'h1111_1111, 32'h0000_2004);
        alu_op(5'd9, 1'b1, 2'b11, 32'hFFFF_FFFF, 32'h0);
        alu_op(5'd0, 1'b1, 2'b00, 32'h0000_0055, 32'h0);
        alu_op(5'd6, 1'b0, 2'b00, 32'h0000_0066, 32'h0);

        // Stray ack while idle must not start or retire anything.
        @(posedge clk); #1;
        dmem_if.dmem_ack = 1'b1;
        @(posedge clk); #1;
        dmem_if.dmem_ack = 1'b0;
        check_eq("idle_ack_req", 32'(dmem_if.dmem_req), 32'd0);
        check_eq("idle_ack_stall", 32'(stall_out), 32'd0);
        check_eq("idle_ack_wren", 32'(wrEn), 32'd0);

        load(5'd3, 3'b000, 32'h0000_0103, 2, 32'h80FF_FFFF);
        load(5'd4, 3'b100, 32'h0000_0103, 2, 32'h80FF_FFFF);
        load(5'd8, 3'b101, 32'h0000_0202, 0, 32'hBEEF_0000);
        load(5'd10, 3'b001, 32'h0000_0200, 1, 32'h1234_8001);
        load(5'd13, 3'b001, 32'h0000_0102, 0, 32'h8001_1234);
        load(5'd0, 3'b010, 32'h0000_0400, 1, 32'h0BAD_F00D);

`ifdef MISALIGN_TRAP_EN
        @(posedge clk); #1;
        valid_in = 1'b1; wb_sel = 2'b01; rd_in = 5'd11; reg_wr_in = 1'b1;
        alu_result = 32'h0000_0301; funct3_in = 3'b010;
        @(posedge clk); #1;
        valid_in = 1'b0;
        check_eq("mis_req", 32'(dmem_if.dmem_req), 32'd0);
        check_eq("mis_trap", 32'(misalign_trap), 32'd1);
        check_eq("mis_stall", 32'(stall_out), 32'd0);
        check_eq("mis_wren", 32'(wrEn), 32'd0);
        @(posedge clk); #1;
        check_eq("mis_trap_pulse", 32'(misalign_trap), 32'd0);
`else
        load(5'd11, 3'b010, 32'h0000_0301, 1, 32'hCAFE_F00D);
        check_eq("mis_trap_tied", 32'(misalign_trap), 32'd0);
`endif

        // Reset during an outstanding load: request drops at once, late ack is ignored.
        @(posedge clk); #1;
        valid_in = 1'b1; wb_sel = 2'b01; rd_in = 5'd12; reg_wr_in = 1'b1;
        alu_result = 32'h0000_0500; funct3_in = 3'b010;
        @(posedge clk); #1;
        valid_in = 1'b0;
        check_eq("rstld_req_pre", 32'(dmem_if.dmem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rstld_req", 32'(dmem_if.dmem_req), 32'd0);
        check_eq("rstld_stall", 32'(stall_out), 32'd0);
        check_eq("rstld_wren", 32'(wrEn), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_if.dmem_ack = 1'b1;
        dmem_if.dmem_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        dmem_if.dmem_ack = 1'b0;
        check_eq("rstld_late_wren", 32'(wrEn), 32'd0);
        check_eq("rstld_late_req", 32'(dmem_if.dmem_req), 32'd0);

        alu_op(5'd1, 1'b1, 2'b00, 32'hA5A5_A5A5, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
